// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Holds the write-back request struct and the requester-ID enum.
package rf_wb_arbiter_pkg;

    // Upper bounds on address and data width carried by wb_req_t. The struct is
    // a transport type: a configured instance zero-extends into it and only the
    // low bits are consumed, so unused upper bits fold away.
    localparam int unsigned WbMaxAddrW = 16;
    localparam int unsigned WbMaxBits  = 256;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic                  valid;
        logic [WbMaxAddrW-1:0] addr;
        logic [WbMaxBits-1:0]  data;
    } wb_req_t;

    // The requester that is not 'id'.
    function automatic req_id_e other_req(req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_hold_buf.sv
// One-entry write-back holding buffer (valid, addr, data, age).
// Ready when empty or when its entry is granted this cycle, so a granted entry
// can be replaced on the same edge without a bubble. Address 0 is accepted but
// never stored. The age bit marks an entry that has already lost arbitration.
module wb_hold_buf #(
    parameter int unsigned AW   = 5,
    parameter int unsigned BITS = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [BITS-1:0] in_data,
    input  logic            grant,
    output logic            buf_valid,
    output logic [AW-1:0]   buf_addr,
    output logic [BITS-1:0] buf_data,
    output logic            buf_age
);

    logic            valid_q, valid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [BITS-1:0] data_q, data_d;
    logic            age_q, age_d;
    logic            load;

    assign in_ready = !valid_q || grant;
    assign load     = in_valid && in_ready && (in_addr != '0);

    // Next-state: load wins over drain; a waiting entry ages.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        age_d   = age_q;
        if (load) begin
            valid_d = 1'b1;
            addr_d  = in_addr;
            data_d  = in_data;
            age_d   = 1'b0;
        end else if (grant) begin
            valid_d = 1'b0;
            age_d   = 1'b0;
        end else if (valid_q) begin
            age_d = 1'b1;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            age_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Payload register; only meaningful while valid_q is set.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign buf_valid = valid_q;
    assign buf_addr  = addr_q;
    assign buf_data  = data_q;
    assign buf_age   = age_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU (A) and load-unit (B) write-backs
// onto a single register-file write port through two one-entry holding buffers.
// Equal-address conflicts go to the older entry (A on a tie). Different-address
// conflicts use round-robin when RF_WB_ROUND_ROBIN_EN is defined, otherwise B
// has fixed priority.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned BITS  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [$clog2(DEPTH)-1:0] a_addr,
    input  logic [BITS-1:0]          a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    input  logic [BITS-1:0]          b_data,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [BITS-1:0]          wr_data,
    output logic [DEPTH-1:0]         busy,
    output logic                     idle
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic            a_buf_valid, b_buf_valid;
    logic [AW-1:0]   a_buf_addr, b_buf_addr;
    logic [BITS-1:0] a_buf_data, b_buf_data;
    logic            a_buf_age, b_buf_age;
    logic            grant_a, grant_b;
    logic            contested;
    req_id_e         grant_id;
    req_id_e         pref_id;
    wb_req_t         req_a, req_b, sel;

    wb_hold_buf #(
        .AW   (AW),
        .BITS (BITS)
    ) u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_valid),
        .in_ready  (a_ready),
        .in_addr   (a_addr),
        .in_data   (a_data),
        .grant     (grant_a),
        .buf_valid (a_buf_valid),
        .buf_addr  (a_buf_addr),
        .buf_data  (a_buf_data),
        .buf_age   (a_buf_age)
    );

    wb_hold_buf #(
        .AW   (AW),
        .BITS (BITS)
    ) u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_addr   (b_addr),
        .in_data   (b_data),
        .grant     (grant_b),
        .buf_valid (b_buf_valid),
        .buf_addr  (b_buf_addr),
        .buf_data  (b_buf_data),
        .buf_age   (b_buf_age)
    );

    // Widen both buffers into the shared request struct.
    always_comb begin
        req_a       = '0;
        req_b       = '0;
        req_a.valid = a_buf_valid;
        req_a.addr  = WbMaxAddrW'(a_buf_addr);
        req_a.data  = WbMaxBits'(a_buf_data);
        req_b.valid = b_buf_valid;
        req_b.addr  = WbMaxAddrW'(b_buf_addr);
        req_b.data  = WbMaxBits'(b_buf_data);
    end

    assign contested = req_a.valid && req_b.valid;

`ifdef RF_WB_ROUND_ROBIN_EN
    req_id_e rr_q, rr_d;

    // Pointer flips after every contested grant, holds otherwise.
    always_comb begin
        rr_d = rr_q;
        if (contested) begin
            rr_d = other_req(rr_q);
        end
    end

    // Round-robin pointer register, starts at A.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= REQ_A;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign pref_id = rr_q;
`else
    assign pref_id = REQ_B;
`endif

    // Pick the granted requester; A is the default when nothing is valid.
    always_comb begin
        grant_id = REQ_A;
        if (contested) begin
            if (req_a.addr == req_b.addr) begin
                // Same destination: keep program order, older entry first.
                grant_id = (b_buf_age && !a_buf_age) ? REQ_B : REQ_A;
            end else begin
                grant_id = pref_id;
            end
        end else if (req_b.valid) begin
            grant_id = REQ_B;
        end
    end

    assign grant_a = req_a.valid && (grant_id == REQ_A);
    assign grant_b = req_b.valid && (grant_id == REQ_B);

    // Drive the write port from the granted buffer; zero when idle.
    always_comb begin
        sel     = (grant_id == REQ_A) ? req_a : req_b;
        wr_en   = sel.valid;
        wr_addr = '0;
        wr_data = '0;
        if (sel.valid) begin
            wr_addr = sel.addr[AW-1:0];
            wr_data = sel.data[BITS-1:0];
        end
    end

    // Upper struct bits beyond the configured widths are intentionally dropped.
    logic unused_sel;
    assign unused_sel = ^{sel.addr, sel.data};

    // Pending-destination scoreboard from the buffer contents.
    always_comb begin
        busy = '0;
        if (req_a.valid) begin
            busy[req_a.addr[AW-1:0]] = 1'b1;
        end
        if (req_b.valid) begin
            busy[req_b.addr[AW-1:0]] = 1'b1;
        end
    end

    assign idle = !req_a.valid && !req_b.valid;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=32, BITS=64).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_data, b_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] busy;
    logic        idle;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] rf_model [32];

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DEPTH (32),
        .BITS  (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .idle    (idle)
    );

    // Register file fed by the write port.
    always @(posedge clk) begin
        if (wr_en) begin
            rf_model[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad, input logic [63:0] d);
        a_valid = v;
        a_addr  = ad;
        a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad, input logic [63:0] d);
        b_valid = v;
        b_addr  = ad;
        b_data  = d;
    endtask

    logic [4:0] first_addr, second_addr;
    logic       exp_a_rdy, exp_b_rdy;

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 5'd0, 64'h0);
        drive_b(1'b0, 5'd0, 64'h0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_b_ready", 64'(b_ready), 64'd1);

        // Single A write
        drive_a(1'b1, 5'd5, 64'h1234);
        step();
        drive_a(1'b0, 5'd0, 64'h0);
        chk("single_wr_en", 64'(wr_en), 64'd1);
        chk("single_wr_addr", 64'(wr_addr), 64'd5);
        chk("single_wr_data", wr_data, 64'h1234);
        chk("single_busy", 64'(busy), 64'h20);
        chk("single_not_idle", 64'(idle), 64'd0);
        step();
        chk("single_idle", 64'(idle), 64'd1);
        chk("single_wr_en_off", 64'(wr_en), 64'd0);
        chk("single_addr_zero", 64'(wr_addr), 64'd0);

        // Contested different addresses
`ifdef RF_WB_ROUND_ROBIN_EN
        first_addr  = 5'd3;
        second_addr = 5'd4;
        exp_a_rdy   = 1'b1;
        exp_b_rdy   = 1'b0;
`else
        first_addr  = 5'd4;
        second_addr = 5'd3;
        exp_a_rdy   = 1'b0;
        exp_b_rdy   = 1'b1;
`endif
        drive_a(1'b1, 5'd3, 64'h33);
        drive_b(1'b1, 5'd4, 64'h44);
        step();
        drive_a(1'b0, 5'd0, 64'h0);
        drive_b(1'b0, 5'd0, 64'h0);
        chk("contest_busy", 64'(busy), 64'h18);
        chk("contest_first", 64'(wr_addr), 64'(first_addr));
        chk("contest_a_ready", 64'(a_ready), 64'(exp_a_rdy));
        chk("contest_b_ready", 64'(b_ready), 64'(exp_b_rdy));
        step();
        chk("contest_second", 64'(wr_addr), 64'(second_addr));
        chk("contest_both_ready", 64'({a_ready, b_ready}), 64'd3);
        step();
        chk("contest_idle", 64'(idle), 64'd1);
        chk("contest_rf3", rf_model[3], 64'h33);
        chk("contest_rf4", rf_model[4], 64'h44);

        // Same address, A one cycle ahead of B
        drive_a(1'b1, 5'd7, 64'hAA);
        step();
        drive_a(1'b0, 5'd0, 64'h0);
        drive_b(1'b1, 5'd7, 64'hBB);
        chk("order_first", wr_data, 64'hAA);
        chk("order_b_ready", 64'(b_ready), 64'd1);
        step();
        drive_b(1'b0, 5'd0, 64'h0);
        chk("order_second", wr_data, 64'hBB);
        chk("order_addr", 64'(wr_addr), 64'd7);
        step();
        chk("order_idle", 64'(idle), 64'd1);
        chk("order_rf7", rf_model[7], 64'hBB);

        // Same address, same edge: A wins the tie, then the aged B beats a fresh A
        drive_a(1'b1, 5'd7, 64'h11);
        drive_b(1'b1, 5'd7, 64'h22);
        step();
        drive_a(1'b1, 5'd7, 64'h33);
        drive_b(1'b0, 5'd0, 64'h0);
        chk("age_tie_data", wr_data, 64'h11);
        chk("age_tie_ready", 64'({a_ready, b_ready}), 64'b10);
        step();
        drive_a(1'b0, 5'd0, 64'h0);
        chk("age_older_data", wr_data, 64'h22);
        chk("age_older_ready", 64'({a_ready, b_ready}), 64'b01);
        step();
        chk("age_last_data", wr_data, 64'h33);
        step();
        chk("age_idle", 64'(idle), 64'd1);
        chk("age_rf7", rf_model[7], 64'h33);

        // Address 0 is swallowed
        drive_b(1'b1, 5'd0, 64'h55);
        chk("zero_b_ready", 64'(b_ready), 64'd1);
        step();
        drive_b(1'b0, 5'd0, 64'h0);
        chk("zero_wr_en", 64'(wr_en), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);
        chk("zero_idle", 64'(idle), 64'd1);

        // A streams four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 5'(10 + i), 64'(256 + i));
            chk("stream_a_ready", 64'(a_ready), 64'd1);
            step();
            chk("stream_wr_en", 64'(wr_en), 64'd1);
            chk("stream_wr_addr", 64'(wr_addr), 64'(10 + i));
        end
        drive_a(1'b0, 5'd0, 64'h0);
        step();
        chk("stream_done", 64'(wr_en), 64'd0);
        chk("stream_rf13", rf_model[13], 64'h103);

        // Reset while both buffers hold entries; handshake on the reset edge is dropped
        drive_a(1'b1, 5'd1, 64'hA1);
        drive_b(1'b1, 5'd2, 64'hB2);
        step();
        chk("mid_busy", 64'(busy), 64'h6);
        chk("mid_wr_en", 64'(wr_en), 64'd1);
        drive_a(1'b1, 5'd8, 64'hA8);
        drive_b(1'b0, 5'd0, 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_a(1'b0, 5'd0, 64'h0);
        chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_idle", 64'(idle), 64'd1);
        chk("rst_mid_ready", 64'({a_ready, b_ready}), 64'd3);
        step();
        chk("rst_mid_still_idle", 64'(idle), 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
